// File: rtl/priority_arbiter_pkg.sv
// priority_arbiter_pkg: shared sizes and state encoding for the 8-way arbiter.
package priority_arbiter_pkg;
  localparam int NUM_REQ = 8;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
endpackage

// File: rtl/prio_enc8_valid.sv
// prio_enc8_valid: picks the highest-priority set bit, searching downward from rot-1 with wrap.
module prio_enc8_valid
  import priority_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [ID_W-1:0]    rot,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);
  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    idx = '0;
    valid = |vec;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (vec[rot - ID_W'(i + 1)]) idx = rot - ID_W'(i + 1);
  end
endmodule

// File: rtl/priority_arbiter_8.sv
// priority_arbiter_8: 8-way arbiter with hold timeout and a one-cycle gap between grants.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed priority (7 highest).
module priority_arbiter_8
  import priority_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [ID_W-1:0] win, rot;
  logic any, hit, rel;
`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] last;
  assign rot = last;
`else
  assign rot = '0;
`endif
  prio_enc8_valid u_enc (.vec(req), .rot(rot), .idx(win), .valid(any));
  assign hit = cnt == CW'(MAX_HOLD - 1);
  assign rel = done || !req[gnt_id] || hit;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      timeout <= 1'b0;
      cnt <= '0;
`ifdef ROUND_ROBIN_EN
      last <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      if (!en || state == GAP || (state == BUSY && rel)) begin
        state <= (en && state == BUSY) ? GAP : IDLE;
        gnt <= '0;
        gnt_id <= '0;
        gnt_valid <= 1'b0;
        // done and a live-request drop both take precedence over a forced release
        timeout <= en && state == BUSY && hit && !done && req[gnt_id];
      end else if (state == IDLE && any) begin
        state <= BUSY;
        gnt <= NUM_REQ'(1) << win;
        gnt_id <= win;
        gnt_valid <= 1'b1;
        cnt <= '0;
`ifdef ROUND_ROBIN_EN
        last <= win;
`endif
      end else if (state == BUSY) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_priority_arbiter_8.sv
// tb_priority_arbiter_8: directed and random checks of priority_arbiter_8 (MAX_HOLD=4) against a grant-level model.
module tb_priority_arbiter_8;
  localparam int MH = 4;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, done = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic gnt_valid, timeout;
  int vecs = 0, errs = 0;
  priority_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  int owner = -1, age = 0, cool = 0, last = 0;
  bit m_to = 1'b0;
  logic [12:0] exp, obs;
  function automatic int pick(logic [7:0] r, int l);
    for (int p = 1; p <= 8; p++) if (r[(l - p + 8) % 8]) return (l - p + 8) % 8;
    return -1;
  endfunction
  // owner: current grantee (-1 none); age: cycles the grant has been visible; cool: pending gap cycle
  always @(posedge clk or posedge rst)
    if (rst) begin
      owner <= -1; age <= 0; cool <= 0; last <= 0; m_to <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!en) begin
        owner <= -1; cool <= 0;
      end else if (owner >= 0) begin
        age <= age + 1;
        if (done || !req[owner] || age + 1 == MH) begin
          m_to <= !done && req[owner] && age + 1 == MH;
          owner <= -1; cool <= 1;
        end
      end else if (cool != 0) cool <= 0;
      else if (req != 0) begin
        owner <= pick(req, last); age <= 0;
        if (RR) last <= pick(req, last);
      end
    end
  always_comb begin
    exp = {8'h00, 3'd0, 1'b0, m_to};
    if (owner >= 0) exp = {8'(1 << owner), 3'(owner), 1'b1, m_to};
  end
  assign obs = {gnt, gnt_id, gnt_valid, timeout};
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      vecs++; if (obs !== 13'h0) begin errs++; $display("FAIL reset obs=%h exp=%h", obs, 13'h0); end
    end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    en = 1'b1; req = 8'h24;
    cyc();
    vecs++; if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin errs++; $display("FAIL basic obs=%h exp=%h", obs, {8'h20, 3'd5, 1'b1, 1'b0}); end
    vecs++; if (obs !== exp) begin errs++; $display("FAIL basic_model obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_preempt();
    bit seen = 1'b0;
    req = 8'hA4;
    cyc();
    vecs++; if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin errs++; $display("FAIL preempt_hold obs=%h exp=%h", obs, {8'h20, 3'd5, 1'b1, 1'b0}); end
    done = 1'b1;
    cyc();
    done = 1'b0;
    vecs++; if (obs !== 13'h0) begin errs++; $display("FAIL preempt_gap obs=%h exp=%h", obs, 13'h0); end
    for (int k = 0; k < 4 && !seen; k++) begin
      cyc();
      vecs++; if (obs !== exp) begin errs++; $display("FAIL preempt_model obs=%h exp=%h", obs, exp); end
      seen = gnt_valid;
    end
    vecs++; if (!seen || gnt_id !== 3'd7) begin errs++; $display("FAIL preempt_next gnt_id=%0d valid=%0b exp=7", gnt_id, gnt_valid); end
    req = 8'h00;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vecs++; if (obs !== exp) begin errs++; $display("FAIL preempt_release obs=%h exp=%h", obs, exp); end
    end
  endtask
  task automatic test_timeout();
    int hv = 0, tc = 0;
    req = 8'h04;
    for (int i = 0; i < 6; i++) begin
      cyc();
      vecs++; if (obs !== exp) begin errs++; $display("FAIL timeout_model obs=%h exp=%h", obs, exp); end
      hv += int'(gnt_valid); tc += int'(timeout);
      if (i == 4) begin
        vecs++; if (obs !== 13'h1) begin errs++; $display("FAIL timeout_pulse obs=%h exp=%h", obs, 13'h1); end
      end
    end
    req = 8'h00;
    vecs++; if (hv != MH || tc != 1) begin errs++; $display("FAIL timeout_len valid_cycles=%0d pulses=%0d exp=%0d/1", hv, tc, MH); end
    for (int k = 0; k < 3; k++) cyc();
  endtask
  task automatic test_async_reset();
    req = 8'h08;
    cyc();
    vecs++; if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin errs++; $display("FAIL arst_grant obs=%h exp=%h", obs, {8'h08, 3'd3, 1'b1, 1'b0}); end
    #3 rst = 1'b1;
    #1;
    vecs++; if (obs !== 13'h0) begin errs++; $display("FAIL arst_async obs=%h exp=%h", obs, 13'h0); end
    cyc();
    vecs++; if (obs !== 13'h0) begin errs++; $display("FAIL arst_held obs=%h exp=%h", obs, 13'h0); end
    rst = 1'b0;
    cyc();
    vecs++; if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin errs++; $display("FAIL arst_resume obs=%h exp=%h", obs, {8'h08, 3'd3, 1'b1, 1'b0}); end
    vecs++; if (obs !== exp) begin errs++; $display("FAIL arst_model obs=%h exp=%h", obs, exp); end
    req = 8'h00;
    for (int k = 0; k < 3; k++) cyc();
  endtask
  task automatic test_en_drop();
    req = 8'h02;
    cyc();
    vecs++; if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin errs++; $display("FAIL en_grant obs=%h exp=%h", obs, {8'h02, 3'd1, 1'b1, 1'b0}); end
    en = 1'b0;
    cyc();
    vecs++; if (obs !== 13'h0) begin errs++; $display("FAIL en_drop obs=%h exp=%h", obs, 13'h0); end
    en = 1'b1;
    cyc();
    vecs++; if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin errs++; $display("FAIL en_regrant obs=%h exp=%h", obs, {8'h02, 3'd1, 1'b1, 1'b0}); end
    req = 8'h00;
    for (int k = 0; k < 3; k++) cyc();
  endtask
  task automatic test_rr();
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      bit seen = 1'b0;
      logic [2:0] want = RR ? 3'(7 - g) : 3'd7;
      for (int k = 0; k < 4 && !seen; k++) begin
        cyc();
        vecs++; if (obs !== exp) begin errs++; $display("FAIL rr_model obs=%h exp=%h", obs, exp); end
        seen = gnt_valid;
      end
      vecs++; if (!seen || gnt_id !== want) begin errs++; $display("FAIL rr_seq grant=%0d gnt_id=%0d valid=%0b exp=%0d", g, gnt_id, gnt_valid, want); end
      done = 1'b1;
      cyc();
      done = 1'b0;
      vecs++; if (obs !== exp) begin errs++; $display("FAIL rr_done obs=%h exp=%h", obs, exp); end
    end
    req = 8'h00;
    for (int k = 0; k < 3; k++) cyc();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      done = $urandom_range(0, 5) == 0;
      cyc();
      vecs++; if (obs !== exp) begin errs++; $display("FAIL random cycle=%0d obs=%h exp=%h", i, obs, exp); end
    end
    done = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_timeout();
    test_async_reset();
    test_en_drop();
    test_rr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
